// File: rtl/count_neighbour_mines_if.sv
// Handshake and data bundle between mine generation, the count builder and the draw path.
// Carries the request, the mine bitmap, the status flags and the three count arrays.
interface count_neighbour_mines_if;
  logic [1:0]              level;
  logic                    start;
  logic [15:0][15:0]       mine_map;
  logic                    busy;
  logic                    done;
  logic [7:0][7:0][2:0]    num_arr_easy;
  logic [9:0][9:0][2:0]    num_arr_medium;
  logic [15:0][15:0][2:0]  num_arr_hard;

  modport master (
    output level,
    output start,
    output mine_map,
    input  busy,
    input  done,
    input  num_arr_easy,
    input  num_arr_medium,
    input  num_arr_hard
  );

  modport slave (
    input  level,
    input  start,
    input  mine_map,
    output busy,
    output done,
    output num_arr_easy,
    output num_arr_medium,
    output num_arr_hard
  );
endinterface

// File: rtl/count_neighbour_mines.sv
// Builds per-cell neighbour-mine counts from a latched bitmap, one cell per clock.
// Optional NUM_CLEAR_ON_START_EN zeroes the selected array when a scan is accepted.
module count_neighbour_mines #(
  parameter int MAX_N = 16,
  parameter int CNT_W = 3
) (
  input logic clk,
  input logic rst,
  count_neighbour_mines_if.slave bus
);

  localparam int IW = $clog2(MAX_N);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_t;

  state_t                  state;
  logic [1:0]              lvl_q;
  logic [15:0][15:0]       map_q;
  logic [IW-1:0]           row_q;
  logic [IW-1:0]           col_q;
  logic                    busy_q;
  logic                    done_q;
  logic [7:0][7:0][2:0]    easy_q;
  logic [9:0][9:0][2:0]    med_q;
  logic [15:0][15:0][2:0]  hard_q;

  logic [IW-1:0]           last_idx;
  logic [IW:0]             rr;
  logic [IW:0]             cc;
  logic [CNT_W:0]          nb;
  logic [CNT_W-1:0]        sat;
  logic                    accept;

  assign accept = bus.start && (bus.level != 2'd0);

  always_comb begin
    last_idx = IW'(MAX_N - 1);
    unique case (lvl_q)
      2'd1:    last_idx = IW'(7);
      2'd2:    last_idx = IW'(9);
      default: last_idx = IW'(MAX_N - 1);
    endcase
  end

  // Offsets are applied in IW+1 bits, so row/col -1 wraps high and fails the bound check.
  always_comb begin
    nb = '0;
    rr = '0;
    cc = '0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        rr = {1'b0, row_q} + (IW+1)'(i) - (IW+1)'(1);
        cc = {1'b0, col_q} + (IW+1)'(j) - (IW+1)'(1);
        if (!(i == 1 && j == 1)
            && rr <= {1'b0, last_idx}
            && cc <= {1'b0, last_idx}) begin
          nb = nb + (CNT_W+1)'(map_q[rr[IW-1:0]][cc[IW-1:0]]);
        end
      end
    end
  end

  assign sat = nb[CNT_W] ? {CNT_W{1'b1}} : nb[CNT_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      lvl_q  <= 2'd0;
      map_q  <= '0;
      row_q  <= '0;
      col_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      easy_q <= '0;
      med_q  <= '0;
      hard_q <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            state  <= SCAN;
            busy_q <= 1'b1;
            lvl_q  <= bus.level;
            map_q  <= bus.mine_map;
            row_q  <= '0;
            col_q  <= '0;
`ifdef NUM_CLEAR_ON_START_EN
            unique case (bus.level)
              2'd1:    easy_q <= '0;
              2'd2:    med_q  <= '0;
              default: hard_q <= '0;
            endcase
`endif
          end
        end
        SCAN: begin
          unique case (lvl_q)
            2'd1:    easy_q[row_q[2:0]][col_q[2:0]] <= sat;
            2'd2:    med_q[row_q][col_q]            <= sat;
            default: hard_q[row_q][col_q]           <= sat;
          endcase
          if (col_q == last_idx) begin
            col_q <= '0;
            if (row_q == last_idx) begin
              state  <= DONE;
              busy_q <= 1'b0;
              done_q <= 1'b1;
              row_q  <= '0;
            end else begin
              row_q <= row_q + 1'b1;
            end
          end else begin
            col_q <= col_q + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.num_arr_easy   = easy_q;
  assign bus.num_arr_medium = med_q;
  assign bus.num_arr_hard   = hard_q;

endmodule
